// File: rtl/frame_bank_pkg.sv
// Shared types and constants for the triple-buffer frame bank arbiter.
// Bank indices, reset bank assignment and write-side FSM encoding.
package frame_bank_pkg;

    typedef logic [1:0] bank_t;

    localparam int    BANK_NUM     = 3;
    localparam bank_t WR_BANK_RST  = 2'd0;
    localparam bank_t RD_BANK_RST  = 2'd1;
    localparam bank_t RDY_BANK_RST = 2'd2;

    typedef enum logic {
        IDLE    = 1'b0,
        WRITING = 1'b1
    } wr_state_t;

endpackage

// File: rtl/frame_bank_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_bank_arbiter.sv
// Triple-buffer bank arbiter between camera write path and VGA read path.
// Writer and reader never share a bank; reader always gets the newest frame.
module frame_bank_arbiter
    import frame_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iWR_START,
    input  logic                 iWR_DONE,
    input  logic                 iRD_START,
    output logic [1:0]           oWR_BANK,
    output logic                 oWR_GRANT,
    output logic [1:0]           oRD_BANK,
    output logic                 oRD_NEW,
    output logic                 oRD_REPEAT,
    output logic [CNT_WIDTH-1:0] oFRAME_CNT,
    output logic [CNT_WIDTH-1:0] oDROP_CNT,
    output logic                 oPROTO_ERR
);

    wr_state_t state, state_n;
    bank_t     wr_bank, wr_bank_n;
    bank_t     rdy_bank, rdy_bank_n;
    bank_t     rd_bank, rd_bank_n;
    logic      rdy_valid, rdy_valid_n;
    logic      rd_new_n, rd_repeat_n, err_n;
    logic      frame_inc, drop_inc;
    logic      done_ok;

    assign done_ok = (state == WRITING) && iWR_DONE;

    always_comb begin
        state_n     = state;
        wr_bank_n   = wr_bank;
        rdy_bank_n  = rdy_bank;
        rd_bank_n   = rd_bank;
        rdy_valid_n = rdy_valid;
        rd_new_n    = 1'b0;
        rd_repeat_n = 1'b0;
        err_n       = oPROTO_ERR;
        frame_inc   = 1'b0;
        drop_inc    = 1'b0;

        if (iWR_DONE && (state == IDLE)) begin
            err_n = 1'b1;
        end

        if (done_ok) begin
            frame_inc = 1'b1;
            drop_inc  = rdy_valid;
            // A START in the same cycle opens the freshly assigned bank
            state_n   = iWR_START ? WRITING : IDLE;
            if (iRD_START) begin
                rd_bank_n   = wr_bank;
                wr_bank_n   = rd_bank;
                rdy_valid_n = 1'b0;
                rd_new_n    = 1'b1;
            end else begin
                wr_bank_n   = rdy_bank;
                rdy_bank_n  = wr_bank;
                rdy_valid_n = 1'b1;
            end
        end else begin
            if (iWR_START) begin
                drop_inc = (state == WRITING);
                state_n  = WRITING;
            end
            if (iRD_START) begin
                if (rdy_valid) begin
                    rd_bank_n   = rdy_bank;
                    rdy_bank_n  = rd_bank;
                    rdy_valid_n = 1'b0;
                    rd_new_n    = 1'b1;
                end else begin
                    rd_repeat_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            wr_bank    <= WR_BANK_RST;
            rdy_bank   <= RDY_BANK_RST;
            rd_bank    <= RD_BANK_RST;
            rdy_valid  <= 1'b0;
            oRD_NEW    <= 1'b0;
            oRD_REPEAT <= 1'b0;
            oPROTO_ERR <= 1'b0;
        end else begin
            state      <= state_n;
            wr_bank    <= wr_bank_n;
            rdy_bank   <= rdy_bank_n;
            rd_bank    <= rd_bank_n;
            rdy_valid  <= rdy_valid_n;
            oRD_NEW    <= rd_new_n;
            oRD_REPEAT <= rd_repeat_n;
            oPROTO_ERR <= err_n;
        end
    end

    assign oWR_BANK  = wr_bank;
    assign oRD_BANK  = rd_bank;
    assign oWR_GRANT = (state == WRITING);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk   (CLK),
        .inc   (frame_inc),
        .clear (RST),
        .count (oFRAME_CNT)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (CLK),
        .inc   (drop_inc),
        .clear (RST),
        .count (oDROP_CNT)
    );

endmodule

// File: doc/frame_bank_arbiter.md
# frame_bank_arbiter

Triple-buffer bank arbiter between the camera write path and the VGA read path of the eye-tracker frame store. Each frame, the writer gets a bank that the reader is not using. The reader always gets the newest completed frame, and neither side ever blocks. The block sits between the camera-side frame events and the MEM bank enables/selects, and replaces the plain field-toggle bank select. Both event streams arrive already synchronised to CLK.

## Interface
- CNT_WIDTH, 16, width of the completed-frame and drop counters
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- iWR_START  in  1  one-cycle pulse, camera frame begins (FVAL rise)
- iWR_DONE  in  1  one-cycle pulse, camera frame completely written
- iRD_START  in  1  one-cycle pulse, display frame begins (VSYNC)
- oWR_BANK  out  2  bank index the writer must write (0..2)
- oWR_GRANT  out  1  write enable gate for MEM port A of oWR_BANK
- oRD_BANK  out  2  bank index the reader must read (0..2)
- oRD_NEW  out  1  one-cycle pulse, oRD_BANK now holds a fresh frame
- oRD_REPEAT  out  1  one-cycle pulse, no new frame, oRD_BANK is re-shown
- oFRAME_CNT  out  CNT_WIDTH  frames completed (iWR_DONE accepted), saturating
- oDROP_CNT  out  CNT_WIDTH  frames lost (aborted or overwritten), saturating
- oPROTO_ERR  out  1  sticky, iWR_DONE received while not writing

## Operation
- Internal registers: wr_bank, rdy_bank, rd_bank (always three distinct values), rdy_valid, writing.
- Reset values:
  - wr_bank=0, rdy_bank=2, rd_bank=1; rdy_valid=0; writing=0.
  - Outputs: oWR_GRANT=0, oRD_NEW=0, oRD_REPEAT=0, both counters=0, oPROTO_ERR=0.
- The write side is a two-state FSM, IDLE and WRITING.
  - IDLE + iWR_START → WRITING. oWR_GRANT=1. wr_bank is unchanged.
  - WRITING + iWR_START → stays in WRITING. The partial frame is aborted, oDROP_CNT+1, and writing restarts on the same bank.
  - WRITING + iWR_DONE → IDLE. oWR_GRANT=0 and oFRAME_CNT+1. wr_bank and rdy_bank swap and rdy_valid=1. If rdy_valid was already 1, the unread ready frame is lost and oDROP_CNT+1.
  - IDLE + iWR_DONE is ignored, except that oPROTO_ERR is set to 1.
- Read side, on iRD_START:
  - If rdy_valid=1: rd_bank and rdy_bank swap, rdy_valid=0, oRD_NEW pulses.
  - Otherwise: rd_bank is unchanged and oRD_REPEAT pulses.
- Simultaneous iWR_DONE (accepted) and iRD_START: the completed frame goes straight to the reader.
  - new rd_bank = old wr_bank; new wr_bank = old rd_bank; rdy_bank is unchanged; rdy_valid=0.
  - oRD_NEW pulses.
  - If rdy_valid was 1, the old ready frame is lost and oDROP_CNT+1.
- Simultaneous iWR_DONE and iWR_START (while WRITING): DONE is processed first, then START opens the new wr_bank. The FSM remains WRITING and oWR_GRANT stays 1.
- If two drop events occur in the same cycle (abort plus overwrite cannot coincide with this rule set), oDROP_CNT increments by at most 1 per cycle.
- Counters saturate at all-ones and never wrap.
- The reader never sees wr_bank. The writer never writes rd_bank.

## Timing
- All outputs are registered. Every output reflects the input event on the cycle after the event (latency 1).
- oRD_NEW and oRD_REPEAT are high for exactly one cycle per iRD_START. Exactly one of them fires.
- oWR_BANK and oRD_BANK change only on the cycle after an accepted event. They are stable otherwise.
- RST asserted mid-frame returns every register to its reset value on the next edge. Events in the reset cycle are ignored.
- Back-to-back pulses on consecutive cycles are each processed in full. No pulse-spacing requirement.

## Structure
- Shared package frame_bank_pkg holds:
  - the bank index type (2 bits);
  - BANK_NUM=3;
  - reset bank constants WR_BANK_RST=0, RD_BANK_RST=1, RDY_BANK_RST=2;
  - write FSM state encoding (IDLE, WRITING).
- One sub-module, sat_counter (parameter WIDTH; inputs inc and clear; output count). It is instantiated twice, once for oFRAME_CNT and once for oDROP_CNT.

## Test plan
- Reset, then iWR_START, then iWR_DONE 10 cycles later → cycle after START: oWR_GRANT=1, oWR_BANK=0. Cycle after DONE: oWR_BANK=2, oWR_GRANT=0, oFRAME_CNT=1.
- Continue with iRD_START → oRD_BANK=0 and oRD_NEW=1 for one cycle. A second iRD_START with no new frame → oRD_REPEAT=1 and oRD_BANK stays 0.
- Two complete writes with no read in between → oDROP_CNT=1. The next iRD_START yields the second frame's bank and oRD_NEW.
- iWR_START twice without DONE → oDROP_CNT=1, oWR_BANK unchanged, oFRAME_CNT=0.
- iWR_DONE and iRD_START in the same cycle from reset+START → oRD_BANK=0, oWR_BANK=1, rdy bank 2 untouched, oRD_NEW=1.
- Random pulse streams over 10^5 cycles:
  - the three bank indices remain distinct every cycle;
  - oWR_GRANT is never high while oWR_BANK==oRD_BANK;
  - iWR_DONE in IDLE sets oPROTO_ERR, which stays set until RST.
